fpga_cfg_wb_loader: RTL
=======================

# fpga_cfg_wb_loader

Wishbone-slave configuration loader in `user_project_wrapper`. It is the responder to the management SoC's config writes: it decodes CTRL/DATA writes in the `0x3000_000x` window and serially shifts per-column config bits into the fabric's column scan chains, one chain per fabric column. The Wishbone `ack` is held off until the shift burst completes, so a master that waits on `ack` is throttled to the fabric's shift rate.

## Interface
Parameters
- `BASE_ADDR`, default `32'h3000_0000`: window base; match on `adr[31:4]`.
- `MX`, default 4: fabric columns, 1..4. Column j uses byte lane j.

Ports
- `wb_clk_i`, in, 1: the block's single clock.
- `wb_rst_i`, in, 1: reset, synchronous, active-low.
- `wbs_stb_i`, in, 1: Wishbone strobe.
- `wbs_cyc_i`, in, 1: Wishbone cycle.
- `wbs_we_i`, in, 1: 1 = write.
- `wbs_sel_i`, in, 4: byte-lane / column enable.
- `wbs_dat_i`, in, 32: write data.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_ack_o`, out, 1: one-cycle acknowledge.
- `wbs_dat_o`, out, 32: read data.
- `cfg_en_o`, out, MX: column shift enable, 1 bit shifted per high cycle.
- `cfg_bit_o`, out, MX: column serial config bit.
- `busy_o`, out, 1: shift burst in progress.

## Operation
- Request: `stb & cyc` and `adr[31:4]==BASE_ADDR[31:4]`; offset = `adr[3:0]`. A non-matching address is ignored, with no ack.
- Offset 1, CTRL write: for each lane j with `sel[j]`, set `cnt[j] = min(dat[8j+:8], 8)`. So 0xFF becomes 8, and 0 means column j is skipped. `cnt` resets to 8.
- Offset 2, DATA write: latch `dat[8j+:8]` into `shreg[j]` for lanes with `sel[j]`. Set `rem[j] = sel[j] ? cnt[j] : 0`. Enter SHIFT.
- Offset 0, STATUS read: `{busy, 7'b0, 24'(total_bits)}`, where `total_bits` is a saturating count of bits shifted in column 0.
- Offset 1 read returns the packed `cnt`. Every other offset or read returns 0 and is still acked.
- SHIFT: each cycle, every column with `rem[j]!=0` drives `cfg_en_o[j]=1` and `cfg_bit_o[j]=shreg[j][0]`, then shifts `shreg[j]` right by one and decrements `rem[j]`. The bit order is LSB first.
  - Leave SHIFT when all `rem` are 0, then go to ACK.
  - If all `rem` are 0 on entry, SHIFT lasts zero cycles and goes straight to ACK.
- FSM states and transitions:
  - IDLE → ACK for CTRL, STATUS and other offsets.
  - IDLE → SHIFT for DATA.
  - SHIFT → ACK.
  - ACK → IDLE.
- In IDLE, `cfg_en_o` and `cfg_bit_o` are 0.
- A request that arrives while busy is not sampled until the FSM is back in IDLE. The master holds `stb` (classic cycle).
- Reset mid-SHIFT: next cycle `cfg_en_o=0` and the FSM is in IDLE. The partial column contents are the software's problem; software re-runs the full load.
- The master must drop `stb` in the cycle after `ack`. If `stb` is still high in IDLE, that is a new request.

## Timing
- Reset values:
  - `wbs_ack_o=0`, `wbs_dat_o=0`, `cfg_en_o=0`, `cfg_bit_o=0`, `busy_o=0`.
  - Every `cnt=8`, `total_bits=0`, FSM=IDLE.
- CTRL, STATUS and other-offset requests: `ack` 1 cycle after the request is sampled, high for exactly 1 cycle. `wbs_dat_o` is valid in the `ack` cycle and 0 otherwise.
- DATA: the request is sampled at edge T. The first `cfg_en_o` is high in cycle T+1, and the last in cycle T+max(rem). `ack` is high in cycle T+max(rem)+1, so total latency is max(rem)+1 cycles.
- `busy_o` is high exactly during SHIFT.
- All outputs are registered.

## Structure
- Package `fpga_cfg_pkg`:
  - offset constants `CFG_OFS_STATUS=0`, `CFG_OFS_CTRL=1`, `CFG_OFS_DATA=2`;
  - the state enum `{IDLE, SHIFT, ACK}`;
  - `CFG_MAX_COLS=4`.
- Natural sub-module: `cfg_col_shifter`, instantiated MX times. It holds the 8-bit shift register, a 4-bit remaining counter, load/shift controls, and the `en`/`bit` outputs.
- The top level keeps the Wishbone decode, the FSM, and `total_bits`.

## Test plan
- Reset, then CTRL write `dat=32'hFFFF_FFFF`, `sel=4'hF` → `ack` 1 cycle later; STATUS read returns `32'h0`; offset 1 read returns `32'h0808_0808`.
- DATA write `32'hA5_3C_0F_81`, `sel=4'hF`, `cnt=8` → 8 cycles of `cfg_en_o=4'hF`. Column 0 bits in time order: 1,0,0,0,0,0,0,1. `ack` at T+9. STATUS then shows `total_bits=8`, `busy=0`.
- CTRL write `32'hFF_FF_FF_03`, then DATA `32'h0000_0006` → only col 0 and others shift. Col 0 runs 3 cycles with bits 0,1,1 and en drops after cycle 3. Cols 1-3 run 8 cycles. `ack` at T+9.
- DATA write with `sel=4'b0101` → only cols 0 and 2 pulse `cfg_en_o`; cols 1 and 3 stay 0. DATA with `sel=0` → no shift, `ack` at T+1.
- Write to `32'h3000_0010` → no `ack`, no state change. Read at offset 7 → `ack` with `dat=0`.
- Reset asserted at cycle 4 of an 8-bit DATA shift → next cycle `cfg_en_o=0`, `busy_o=0`, no `ack`. A subsequent CTRL write is acked normally.

Source files
------------

// File: rtl/fpga_cfg_wb_loader_pkg.sv
// fpga_cfg_pkg: shared constants, FSM state type and count helper for the
// Wishbone configuration loader.
//   CFG_OFS_*    : register offsets within the 16-byte window (adr[3:0])
//   CFG_MAX_COLS : upper bound on the number of fabric columns (MX)
//   cfg_state_e  : loader FSM states
//   cfg_sat_cnt  : clamp a per-column bit count byte to 0..8
package fpga_cfg_pkg;

   localparam logic [3:0] CFG_OFS_STATUS = 4'd0;
   localparam logic [3:0] CFG_OFS_CTRL   = 4'd1;
   localparam logic [3:0] CFG_OFS_DATA   = 4'd2;
   localparam int         CFG_MAX_COLS   = 4;
   localparam logic [3:0] CFG_CNT_MAX    = 4'd8;

   typedef enum logic [1:0] {IDLE, SHIFT, ACK} cfg_state_e;

   function automatic logic [3:0] cfg_sat_cnt(input logic [7:0] b);
      return (b > 8'(CFG_CNT_MAX)) ? CFG_CNT_MAX : b[3:0];
   endfunction

endpackage

// File: rtl/fpga_cfg_wb_loader_if.sv
// fpga_cfg_wb_loader_if: Wishbone slave bus between the management SoC and
// the configuration loader.
//   master modport : drives stb/cyc/we/sel/dat_i/adr, receives ack/dat_o
//   slave  modport : the loader side
interface fpga_cfg_wb_loader_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/fpga_cfg_wb_loader_col_shifter.sv
// cfg_col_shifter: one fabric column's serial config shifter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : capture data_i/cnt_i; the first bit appears next cycle
//   shift_i       : advance one bit while bits remain
//   data_i        : 8 config bits, shifted out LSB first
//   cnt_i         : number of bits to shift (0..8, 0 = column idle)
//   en_o, bit_o   : registered column shift enable and serial bit
//   rem_nz_o      : more bits remain after the one currently on bit_o
module cfg_col_shifter (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic [7:0] data_i,
   input  logic [3:0] cnt_i,
   output logic       en_o,
   output logic       bit_o,
   output logic       rem_nz_o
);

   logic [7:0] shreg_q, shreg_d;
   logic [3:0] rem_q, rem_d;
   logic       en_q, en_d, bit_q, bit_d;

   // The load cycle already presents bit 0, so rem counts the bits still
   // waiting behind the one on the output.
   always_comb begin
      shreg_d = shreg_q;
      rem_d   = rem_q;
      en_d    = 1'b0;
      bit_d   = 1'b0;
      if (load_i) begin
         rem_d = 4'd0;
         if (cnt_i != 4'd0) begin
            en_d    = 1'b1;
            bit_d   = data_i[0];
            shreg_d = {1'b0, data_i[7:1]};
            rem_d   = cnt_i - 4'd1;
         end
      end else if (shift_i && rem_q != 4'd0) begin
         en_d    = 1'b1;
         bit_d   = shreg_q[0];
         shreg_d = {1'b0, shreg_q[7:1]};
         rem_d   = rem_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         shreg_q <= '0;
         rem_q   <= '0;
         en_q    <= 1'b0;
         bit_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         en_q    <= en_d;
         bit_q   <= bit_d;
      end
   end

   assign en_o     = en_q;
   assign bit_o    = bit_q;
   assign rem_nz_o = (rem_q != 4'd0);

endmodule

// File: rtl/fpga_cfg_wb_loader.sv
// fpga_cfg_wb_loader: Wishbone slave that shifts per-column config bits into
// the fabric scan chains; ack is withheld until the shift burst is done.
//   wb_clk_i, wb_rst_i : clock, synchronous active-low reset
//   wbs                : Wishbone slave bus (fpga_cfg_wb_loader_if.slave)
//   cfg_en_o/cfg_bit_o : per-column shift enable and serial bit
//   busy_o             : high while a shift burst is running
module fpga_cfg_wb_loader
   import fpga_cfg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          MX        = 4   // 1..CFG_MAX_COLS
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   fpga_cfg_wb_loader_if.slave  wbs,
   output logic [MX-1:0]        cfg_en_o,
   output logic [MX-1:0]        cfg_bit_o,
   output logic                 busy_o
);

   cfg_state_e           state_q;
   logic                 ack_q, busy_q;
   logic [31:0]          dat_q;
   logic [MX-1:0][3:0]   cnt_q;
   logic [23:0]          total_q;

   logic                 req, wr_ctrl, wr_data, load, any_load;
   logic [3:0]           ofs;
   logic [MX-1:0][3:0]   load_cnt;
   logic [MX-1:0]        rem_nz;
   logic [31:0]          rd_data;

   assign ofs     = wbs.wbs_adr_i[3:0];
   assign req     = wbs.wbs_stb_i && wbs.wbs_cyc_i &&
                    (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign wr_ctrl = wbs.wbs_we_i && (ofs == CFG_OFS_CTRL);
   assign wr_data = wbs.wbs_we_i && (ofs == CFG_OFS_DATA);
   // Requests are only sampled in IDLE; a held stb during a burst waits.
   assign load    = (state_q == IDLE) && req && wr_data;

   always_comb begin
      any_load = 1'b0;
      rd_data  = '0;
      for (int j = 0; j < MX; j++) begin
         load_cnt[j] = wbs.wbs_sel_i[j] ? cnt_q[j] : 4'd0;
         if (load_cnt[j] != 4'd0) any_load = 1'b1;
      end
      if (!wbs.wbs_we_i) begin
         if (ofs == CFG_OFS_STATUS)
            rd_data = {busy_q, 7'b0, total_q};
         else if (ofs == CFG_OFS_CTRL)
            for (int j = 0; j < MX; j++) rd_data[8*j +: 8] = {4'b0, cnt_q[j]};
      end
   end

   for (genvar j = 0; j < MX; j++) begin : g_col
      cfg_col_shifter u_col (
         .clk_i    (wb_clk_i),
         .rst_ni   (wb_rst_i),
         .load_i   (load),
         .shift_i  (state_q == SHIFT),
         .data_i   (wbs.wbs_dat_i[8*j +: 8]),
         .cnt_i    (load_cnt[j]),
         .en_o     (cfg_en_o[j]),
         .bit_o    (cfg_bit_o[j]),
         .rem_nz_o (rem_nz[j])
      );
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         dat_q   <= '0;
         total_q <= '0;
         for (int j = 0; j < MX; j++) cnt_q[j] <= CFG_CNT_MAX;
      end else begin
         ack_q <= 1'b0;
         dat_q <= '0;
         // Count column-0 bits as they leave, saturating at all-ones.
         if (cfg_en_o[0] && total_q != '1) total_q <= total_q + 24'd1;
         case (state_q)
            IDLE: if (req) begin
               if (wr_data && any_load) begin
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= rd_data;
                  if (wr_ctrl)
                     for (int j = 0; j < MX; j++)
                        if (wbs.wbs_sel_i[j])
                           cnt_q[j] <= cfg_sat_cnt(wbs.wbs_dat_i[8*j +: 8]);
               end
            end
            // rem_nz low everywhere means the bits now on the outputs are
            // the last ones, so ack lands the cycle after the final enable.
            SHIFT: if (rem_nz == '0) begin
               state_q <= ACK;
               busy_q  <= 1'b0;
               ack_q   <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign busy_o        = busy_q;

endmodule
